mul_div_reservation_station: RTL and testbench
==============================================

Name: mul_div_reservation_station

Overview:
- Reservation station directly upstream of the mul/div functional unit in the Tomasulo datapath.
- Accepts MUL/DIV instructions from the issue stage and holds them until both operands are available. Operands arrive either at issue or by snooping the common data bus (CDB).
- Dispatches one ready entry at a time to the FU, holds the FU inputs stable until the FU reports Done, then frees the entry.

Parameters:
- DATA_W, 9, operand/result width (matches FU RegX/RegY).
- TAG_W, 3, producer tag / label width.
- DEPTH, 3, number of station entries (1..4).
- TAG_BASE, 4, tag of entry 0; entry i owns tag TAG_BASE+i. Tags must be nonzero and unique system-wide.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- issue_valid  in  1  issue stage presents an instruction.
- issue_ready  out  1  a free entry exists (from registered state).
- issue_op  in  3  opcode; 3'b010 MUL, 3'b011 DIV.
- issue_dest  in  3  destination register address.
- issue_vj, issue_vk  in  DATA_W  operand values.
- issue_rj, issue_rk  in  1  operand value valid; when 0, the operand waits on issue_qj/issue_qk.
- issue_qj, issue_qk  in  TAG_W  producer tag of the pending operand.
- issue_tag  out  TAG_W  tag of the entry that accepts the current issue (valid when issue_valid&&issue_ready).
- cdb_valid  in  1  CDB broadcast this cycle.
- cdb_tag  in  TAG_W  broadcasting producer tag.
- cdb_data  in  DATA_W  broadcast value.
- fu_run  out  1  to FU RUN.
- fu_x, fu_y  out  DATA_W  to FU RegX/RegY.
- fu_op  out  3  to FU OpCode; 3'b000 when not running.
- fu_dest  out  3  to FU InputX_MulDiv.
- fu_label  out  TAG_W  to FU InputLabel_MulDiv; the tag of the executing entry.
- fu_done  in  1  FU Done.
- busy_count  out  3  number of occupied entries.

Behaviour:
- Entry fields: busy, op, dest, vj, vk, rj, rk, qj, qk.
- Reset: all busy=0. FSM in IDLE. fu_run=0, fu_op=0, fu_x=fu_y=0, fu_dest=fu_label=0, busy_count=0. Reset mid-EXEC aborts the operation, and fu_run is 0 the next cycle.
- Issue:
  - Accepted on the edge where issue_valid && issue_ready && issue_op is 010 or 011.
  - Any other opcode is ignored: nothing is written and issue_tag is don't-care.
  - The lowest-index free entry is allocated; issue_tag = TAG_BASE + index (combinational).
- CDB snoop: on every edge with cdb_valid, every busy entry with rj=0 && qj==cdb_tag takes vj=cdb_data and sets rj=1; likewise for k.
- Issue-cycle forwarding: if an issuing operand has r=0 and q==cdb_tag with cdb_valid high in the same cycle, the entry is written with the CDB value and r=1.
- FSM IDLE:
  - If any entry has busy&&rj&&rk and is not the entry freed this edge, select the lowest index ready entry.
  - Latch its fields into the fu_* registers, set fu_run=1, go to EXEC. This takes 1 edge.
  - Ready state is registered, so an operand captured from the CDB on edge N makes its entry dispatchable on edge N+1 at the earliest.
- FSM EXEC:
  - fu_x/fu_y/fu_op/fu_dest/fu_label held constant and fu_run=1.
  - On the edge where fu_done=1: the entry's busy clears, fu_run=0, fu_op=0, go to IDLE.
  - fu_run is low for at least one cycle between operations, so the FU counters restart cleanly.
- Simultaneous events:
  - An entry freed on edge N is not reported by issue_ready until after N.
  - Issue and dispatch on the same edge are independent; a newly issued entry cannot be dispatched on its issue edge.
  - A CDB broadcast with cdb_tag equal to a tag this station owns is treated like any other tag.
- issue_ready = 0 when all DEPTH entries are busy (full). With no ready entry, IDLE holds.
- Arithmetic is not performed here; division by zero passes through to the FU unchanged.
- busy_count is registered and equals the popcount of busy.

Test Plan:
- Reset, then issue MUL dest=2 vj=5 vk=7, both ready -> issue_tag=4; fu_run rises the next edge with fu_x=5, fu_y=7, fu_op=010, fu_label=4. The FU returns 35 with Done. The entry frees, busy_count goes 1->0 and fu_run drops.
- Issue DIV vj=20, rk=0, qk=1; 3 cycles later cdb_valid tag=1 data=4 -> vk=4 captured; dispatch on the following edge with fu_y=4; FU result 5.
- Issue with rj=0, qj=2 in the same cycle as CDB tag=2 data=9 -> entry stores vj=9 ready and dispatches on the next edge.
- Fill 3 entries with unready operands -> issue_ready=0 and a 4th issue_valid is not accepted. Broadcast the tag for entry 1 -> entry 1 dispatches first; after Done, issue_ready=1 and a new issue lands in entry 1 (tag 5).
- Issue op=3'b001 -> not accepted, busy_count stays 0.
- Assert reset during EXEC of a DIV -> next cycle fu_run=0, busy_count=0, issue_ready=1, and a later fu_done has no effect.

Source files
------------

// File: rtl/mul_div_reservation_station.sv
// Reservation station feeding the mul/div functional unit.
// Holds MUL/DIV instructions until both operands are present (from issue or
// by snooping the CDB), dispatches the lowest-index ready entry, keeps the FU
// inputs stable while the FU runs, and frees the entry when the FU reports done.
//
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   issue_valid/ready/op/dest      issue handshake, opcode, destination register
//   issue_vj/vk/rj/rk/qj/qk        operand values, valid flags, producer tags
//   issue_tag                      tag of the entry taking the current issue
//   cdb_valid/tag/data             common data bus broadcast
//   fu_run/x/y/op/dest/label       functional unit inputs
//   fu_done                        functional unit completion
//   busy_count                     number of occupied entries
module mul_div_reservation_station #(
  parameter int DATA_W   = 9,
  parameter int TAG_W    = 3,
  parameter int DEPTH    = 3,
  parameter int TAG_BASE = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [2:0]        issue_op,
  input  logic [2:0]        issue_dest,
  input  logic [DATA_W-1:0] issue_vj,
  input  logic [DATA_W-1:0] issue_vk,
  input  logic              issue_rj,
  input  logic              issue_rk,
  input  logic [TAG_W-1:0]  issue_qj,
  input  logic [TAG_W-1:0]  issue_qk,
  output logic [TAG_W-1:0]  issue_tag,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  output logic              fu_run,
  output logic [DATA_W-1:0] fu_x,
  output logic [DATA_W-1:0] fu_y,
  output logic [2:0]        fu_op,
  output logic [2:0]        fu_dest,
  output logic [TAG_W-1:0]  fu_label,
  input  logic              fu_done,
  output logic [2:0]        busy_count
);

  localparam int         IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;

  typedef enum logic {IDLE, EXEC} state_t;

  state_t state;

  logic [DEPTH-1:0]  busy, rj, rk;
  logic [2:0]        op_e   [DEPTH];
  logic [2:0]        dest_e [DEPTH];
  logic [DATA_W-1:0] vj_e   [DEPTH];
  logic [DATA_W-1:0] vk_e   [DEPTH];
  logic [TAG_W-1:0]  qj_e   [DEPTH];
  logic [TAG_W-1:0]  qk_e   [DEPTH];

  logic [IDX_W-1:0]  free_idx, rdy_idx, exec_idx;
  logic              any_rdy, issue_fire, fwd_j, fwd_k, fu_free;
  logic [DEPTH-1:0]  snoop_j, snoop_k, busy_nxt, rj_nxt, rk_nxt;

  function automatic logic [2:0] popcnt(input logic [DEPTH-1:0] b);
    logic [2:0] c;
    c = '0;
    for (int i = 0; i < DEPTH; i++) c = c + 3'(b[i]);
    return c;
  endfunction

  // Lowest free and lowest ready entry; scanning downward leaves the lowest.
  always_comb begin
    free_idx = '0;
    rdy_idx  = '0;
    any_rdy  = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!busy[i]) free_idx = IDX_W'(i);
      if (busy[i] && rj[i] && rk[i]) begin
        rdy_idx = IDX_W'(i);
        any_rdy = 1'b1;
      end
    end
  end

  assign issue_ready = ~&busy;
  assign issue_tag   = TAG_W'(TAG_BASE + int'(free_idx));
  assign issue_fire  = issue_valid && issue_ready && (issue_op == OP_MUL || issue_op == OP_DIV);
  // An operand broadcast in the issue cycle is captured directly.
  assign fwd_j       = cdb_valid && !issue_rj && (issue_qj == cdb_tag);
  assign fwd_k       = cdb_valid && !issue_rk && (issue_qk == cdb_tag);
  assign fu_free     = (state == EXEC) && fu_done;

  always_comb begin
    busy_nxt = busy;
    rj_nxt   = rj;
    rk_nxt   = rk;
    for (int i = 0; i < DEPTH; i++) begin
      snoop_j[i] = cdb_valid && busy[i] && !rj[i] && (qj_e[i] == cdb_tag);
      snoop_k[i] = cdb_valid && busy[i] && !rk[i] && (qk_e[i] == cdb_tag);
      if (snoop_j[i]) rj_nxt[i] = 1'b1;
      if (snoop_k[i]) rk_nxt[i] = 1'b1;
      if (fu_free && exec_idx == IDX_W'(i)) busy_nxt[i] = 1'b0;
      if (issue_fire && free_idx == IDX_W'(i)) begin
        busy_nxt[i] = 1'b1;
        rj_nxt[i]   = issue_rj || fwd_j;
        rk_nxt[i]   = issue_rk || fwd_k;
      end
    end
  end

  // Entry payload: written on issue, operand values refreshed by CDB snoop.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (issue_fire && free_idx == IDX_W'(i)) begin
        op_e[i]   <= issue_op;
        dest_e[i] <= issue_dest;
        qj_e[i]   <= issue_qj;
        qk_e[i]   <= issue_qk;
        vj_e[i]   <= fwd_j ? cdb_data : issue_vj;
        vk_e[i]   <= fwd_k ? cdb_data : issue_vk;
      end else begin
        if (snoop_j[i]) vj_e[i] <= cdb_data;
        if (snoop_k[i]) vk_e[i] <= cdb_data;
      end
    end
  end

  // Entry status and dispatch FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy       <= '0;
      rj         <= '0;
      rk         <= '0;
      busy_count <= '0;
      state      <= IDLE;
      exec_idx   <= '0;
      fu_run     <= 1'b0;
      fu_op      <= 3'b000;
      fu_x       <= '0;
      fu_y       <= '0;
      fu_dest    <= '0;
      fu_label   <= '0;
    end else begin
      busy       <= busy_nxt;
      rj         <= rj_nxt;
      rk         <= rk_nxt;
      busy_count <= popcnt(busy_nxt);
      case (state)
        IDLE: begin
          if (any_rdy) begin
            fu_x     <= vj_e[rdy_idx];
            fu_y     <= vk_e[rdy_idx];
            fu_op    <= op_e[rdy_idx];
            fu_dest  <= dest_e[rdy_idx];
            fu_label <= TAG_W'(TAG_BASE + int'(rdy_idx));
            exec_idx <= rdy_idx;
            fu_run   <= 1'b1;
            state    <= EXEC;
          end
        end
        EXEC: begin
          // Returning through IDLE guarantees fu_run drops for a cycle.
          if (fu_done) begin
            fu_run <= 1'b0;
            fu_op  <= 3'b000;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_reservation_station.sv
module tb_mul_div_reservation_station;
  localparam int DATA_W = 9, TAG_W = 3, DEPTH = 3, TAG_BASE = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset, issue_valid, issue_ready, issue_rj, issue_rk;
  logic [2:0]        issue_op, issue_dest, fu_op, fu_dest, busy_count;
  logic [DATA_W-1:0] issue_vj, issue_vk, cdb_data, fu_x, fu_y;
  logic [TAG_W-1:0]  issue_qj, issue_qk, issue_tag, cdb_tag, fu_label;
  logic              cdb_valid, fu_run, fu_done;

  mul_div_reservation_station #(.DATA_W(DATA_W), .TAG_W(TAG_W), .DEPTH(DEPTH), .TAG_BASE(TAG_BASE)) dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
    .issue_dest(issue_dest), .issue_vj(issue_vj), .issue_vk(issue_vk),
    .issue_rj(issue_rj), .issue_rk(issue_rk), .issue_qj(issue_qj), .issue_qk(issue_qk),
    .issue_tag(issue_tag), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .fu_run(fu_run), .fu_x(fu_x), .fu_y(fu_y), .fu_op(fu_op), .fu_dest(fu_dest),
    .fu_label(fu_label), .fu_done(fu_done), .busy_count(busy_count)
  );

  // Reference model: a table of station entries plus the FU-side view.
  bit m_busy[DEPTH], m_rj[DEPTH], m_rk[DEPTH];
  int m_op[DEPTH], m_dest[DEPTH], m_vj[DEPTH], m_vk[DEPTH], m_qj[DEPTH], m_qk[DEPTH];
  bit m_exec;
  int m_idx, m_fx, m_fy, m_fop, m_fdest, m_flabel;
  int fu_cnt, fu_lat;
  bit auto_fu = 1'b1;
  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int m_cnt();
    int c = 0;
    for (int i = 0; i < DEPTH; i++) c += int'(m_busy[i]);
    return c;
  endfunction

  function automatic int m_free();
    for (int i = 0; i < DEPTH; i++) if (!m_busy[i]) return i;
    return -1;
  endfunction

  function automatic bit op_ok(input logic [2:0] op);
    return op == 3'b010 || op == 3'b011;
  endfunction

  task automatic model_edge();
    int alloc, disp;
    bit done;
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) m_busy[i] = 1'b0;
      m_exec = 1'b0; m_fx = 0; m_fy = 0; m_fop = 0; m_fdest = 0; m_flabel = 0;
      return;
    end
    alloc = (issue_valid && op_ok(issue_op)) ? m_free() : -1;
    disp = -1;
    if (!m_exec)
      for (int i = DEPTH - 1; i >= 0; i--) if (m_busy[i] && m_rj[i] && m_rk[i]) disp = i;
    done = m_exec && fu_done;
    if (cdb_valid)
      for (int i = 0; i < DEPTH; i++)
        if (m_busy[i]) begin
          if (!m_rj[i] && m_qj[i] == int'(cdb_tag)) begin m_vj[i] = int'(cdb_data); m_rj[i] = 1'b1; end
          if (!m_rk[i] && m_qk[i] == int'(cdb_tag)) begin m_vk[i] = int'(cdb_data); m_rk[i] = 1'b1; end
        end
    if (done) begin
      m_busy[m_idx] = 1'b0; m_exec = 1'b0; m_fop = 0;
    end else if (m_exec) fu_cnt++;
    if (disp >= 0) begin
      m_fx = m_vj[disp]; m_fy = m_vk[disp]; m_fop = m_op[disp]; m_fdest = m_dest[disp];
      m_flabel = TAG_BASE + disp; m_idx = disp; m_exec = 1'b1;
      fu_cnt = 0; fu_lat = $urandom_range(0, 3);
    end
    if (alloc >= 0) begin
      m_busy[alloc] = 1'b1; m_op[alloc] = int'(issue_op); m_dest[alloc] = int'(issue_dest);
      m_qj[alloc] = int'(issue_qj); m_qk[alloc] = int'(issue_qk);
      m_rj[alloc] = issue_rj || (cdb_valid && issue_qj == cdb_tag);
      m_rk[alloc] = issue_rk || (cdb_valid && issue_qk == cdb_tag);
      m_vj[alloc] = issue_rj ? int'(issue_vj) : (m_rj[alloc] ? int'(cdb_data) : 0);
      m_vk[alloc] = issue_rk ? int'(issue_vk) : (m_rk[alloc] ? int'(cdb_data) : 0);
    end
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic step();
    #1;
    if (auto_fu) fu_done = m_exec ? (fu_cnt >= fu_lat) : ($urandom_range(0, 7) == 0);
    #1;
    chk("issue_ready", issue_ready, m_cnt() < DEPTH);
    chk("busy_count", busy_count, m_cnt());
    chk("fu_run", fu_run, m_exec);
    chk("fu_x", fu_x, m_fx);
    chk("fu_y", fu_y, m_fy);
    chk("fu_op", fu_op, m_fop);
    chk("fu_dest", fu_dest, m_fdest);
    chk("fu_label", fu_label, m_flabel);
    if (!reset && issue_valid && op_ok(issue_op) && m_cnt() < DEPTH)
      chk("issue_tag", issue_tag, TAG_BASE + m_free());
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic clr_in();
    issue_valid = 0; issue_op = 0; issue_dest = 0; issue_vj = 0; issue_vk = 0;
    issue_rj = 0; issue_rk = 0; issue_qj = 0; issue_qk = 0;
    cdb_valid = 0; cdb_tag = 0; cdb_data = 0;
  endtask

  task automatic issue_set(input logic [2:0] op, input logic [2:0] dest, input int vj, input int vk,
                           input bit rj, input bit rk, input int qj, input int qk);
    issue_valid = 1; issue_op = op; issue_dest = dest;
    issue_vj = DATA_W'(vj); issue_vk = DATA_W'(vk);
    issue_rj = rj; issue_rk = rk; issue_qj = TAG_W'(qj); issue_qk = TAG_W'(qk);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 20 && fu_run; k++) step();
    chk("wait_idle", fu_run, 0);
  endtask

  initial begin
    clr_in();
    fu_done = 0;
    reset = 1;
    @(posedge clk); model_edge(); @(negedge clk);
    step();
    reset = 0;
    step();

    // Ready MUL dispatches the edge after issue.
    issue_set(3'b010, 2, 5, 7, 1, 1, 0, 0);
    #1 chk("t1_tag", issue_tag, 4);
    step(); clr_in();
    chk("t1_cnt", busy_count, 1);
    chk("t1_run0", fu_run, 0);
    step();
    chk("t1_run", fu_run, 1); chk("t1_x", fu_x, 5); chk("t1_y", fu_y, 7);
    chk("t1_op", fu_op, 2); chk("t1_lab", fu_label, 4);
    wait_idle();
    chk("t1_free", busy_count, 0);

    // DIV waits on tag 1 for vk.
    issue_set(3'b011, 1, 20, 0, 1, 0, 0, 1);
    step(); clr_in();
    step(); step();
    cdb_valid = 1; cdb_tag = 1; cdb_data = 4;
    step(); clr_in();
    chk("t2_run0", fu_run, 0);
    step();
    chk("t2_run", fu_run, 1); chk("t2_x", fu_x, 20); chk("t2_y", fu_y, 4); chk("t2_op", fu_op, 3);
    wait_idle();

    // Issue-cycle forwarding from the CDB.
    issue_set(3'b010, 3, 0, 6, 0, 1, 2, 0);
    cdb_valid = 1; cdb_tag = 2; cdb_data = 9;
    step(); clr_in();
    chk("t3_run0", fu_run, 0);
    step();
    chk("t3_run", fu_run, 1); chk("t3_x", fu_x, 9); chk("t3_y", fu_y, 6);
    wait_idle();

    // Full station, out-of-order wakeup, reuse of the freed slot.
    issue_set(3'b010, 1, 0, 1, 0, 1, 1, 0); step();
    issue_set(3'b010, 2, 0, 2, 0, 1, 2, 0); step();
    issue_set(3'b011, 3, 0, 3, 0, 1, 3, 0); step();
    issue_set(3'b010, 4, 8, 8, 1, 1, 0, 0);
    #1 chk("t4_full", issue_ready, 0);
    step(); clr_in();
    chk("t4_cnt", busy_count, 3);
    cdb_valid = 1; cdb_tag = 2; cdb_data = 11;
    step(); clr_in();
    step();
    chk("t4_lab", fu_label, 5); chk("t4_x", fu_x, 11);
    wait_idle();
    chk("t4_ready", issue_ready, 1);
    issue_set(3'b010, 5, 1, 1, 0, 0, 1, 3);
    #1 chk("t4_tag", issue_tag, 5);
    step(); clr_in();
    reset = 1; step(); reset = 0;

    // Unsupported opcode is ignored.
    issue_set(3'b001, 2, 1, 1, 1, 1, 0, 0);
    step(); clr_in();
    chk("t5_cnt", busy_count, 0);
    step();
    chk("t5_run", fu_run, 0);

    // Reset during EXEC aborts; a late done is ignored.
    auto_fu = 0; fu_done = 0;
    issue_set(3'b011, 4, 100, 0, 1, 1, 0, 0);
    step(); clr_in();
    step();
    chk("t6_run", fu_run, 1); chk("t6_y", fu_y, 0);
    step(); step();
    reset = 1; step(); reset = 0;
    chk("t6_run0", fu_run, 0); chk("t6_cnt", busy_count, 0); chk("t6_rdy", issue_ready, 1);
    fu_done = 1; step(); fu_done = 0;
    chk("t6_run1", fu_run, 0); chk("t6_cnt1", busy_count, 0);
    auto_fu = 1;

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      int r;
      reset = ($urandom_range(0, 299) == 0);
      issue_valid = $urandom_range(0, 1);
      r = $urandom_range(0, 9);
      issue_op = (r == 0) ? 3'($urandom_range(0, 7)) : ((r < 5) ? 3'b010 : 3'b011);
      issue_dest = 3'($urandom_range(0, 7));
      issue_vj = DATA_W'($urandom); issue_vk = DATA_W'($urandom);
      issue_rj = $urandom_range(0, 1); issue_rk = $urandom_range(0, 1);
      issue_qj = TAG_W'($urandom_range(1, 3)); issue_qk = TAG_W'($urandom_range(1, 3));
      cdb_valid = $urandom_range(0, 1);
      cdb_tag = TAG_W'($urandom_range(0, 7));
      cdb_data = DATA_W'($urandom);
      step();
    end
    reset = 0; clr_in();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
